// File: rtl/alu_accum_seq_if.sv
// alu_accum_seq_if
//   Bundles the operation handshake, load path, error clear and status
//   outputs of alu_accum_seq. The master side (the requester) drives the
//   controls and operands; the slave side (the ALU) drives the status.
//   en           power enable (level)
//   load         load load_val into the accumulator
//   load_val     load value
//   op_valid     operation request
//   op_ready     ALU can accept an operation this cycle
//   opcode       0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MUL, 7 CLR
//   operand      second operand, sampled at acceptance
//   clr_err      leave ERROR state
//   acc          registered accumulator
//   result_valid one-cycle pulse after each completed operation
//   overflow     overflow flag of the last completed operation
//   state        00 OFF, 01 READY, 10 RUN, 11 ERROR
interface alu_accum_seq_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic             clr_err;
  logic [WIDTH-1:0] acc;
  logic             result_valid;
  logic             overflow;
  logic [1:0]       state;

  modport master (
    output en, load, load_val, op_valid, opcode, operand, clr_err,
    input  op_ready, acc, result_valid, overflow, state
  );

  modport slave (
    input  en, load, load_val, op_valid, opcode, operand, clr_err,
    output op_ready, acc, result_valid, overflow, state
  );
endinterface

// File: rtl/alu_accum_seq.sv
// alu_accum_seq
//   WIDTH-generic accumulator ALU. Holds a running accumulator, accepts one
//   operation at a time against a supplied operand, runs MUL as a WIDTH-cycle
//   shift-add, and latches overflow into a sticky ERROR state released only
//   by clr_err. Dropping en returns to OFF and clears acc/overflow.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of alu_accum_seq_if (handshake, operands, status)
module alu_accum_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_accum_seq_if.slave bus
);

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_READY = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  localparam logic [2:0] OP_MUL = 3'd6;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]         stateQ;
  logic [WIDTH-1:0]   accQ;
  logic               ovfQ;
  logic               resultValidQ;
  logic [CNT_W-1:0]   cntQ;
  logic [2*WIDTH-1:0] mcandQ;
  logic [WIDTH-1:0]   mplierQ;
  logic [2*WIDTH-1:0] prodQ;

  logic               opReady;
  logic               accept;
  logic [WIDTH:0]     aluOut;
  logic [2*WIDTH-1:0] stepProd;

  // Single-cycle ops; MSB of the return value is the overflow flag.
  function automatic logic [WIDTH:0] aluOp(input logic [2:0] opc,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] res;
    res = '0;
    case (opc)
      3'd0:    res = {1'b0, a & b};
      3'd1:    res = {1'b0, a | b};
      3'd2:    res = {1'b0, a ^ b};
      3'd3:    res = {1'b0, ~a};
      3'd4:    res = {1'b0, a} + {1'b0, b};
      // Borrow out of the extended subtraction lands in the MSB (a < b).
      3'd5:    res = {1'b0, a} - {1'b0, b};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign opReady  = (stateQ == ST_READY) & ~bus.load & bus.en;
  assign accept   = bus.op_valid & opReady;
  assign aluOut   = aluOp(bus.opcode, accQ, bus.operand);
  assign stepProd = prodQ + (mplierQ[0] ? mcandQ : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ       <= ST_OFF;
      accQ         <= '0;
      ovfQ         <= 1'b0;
      resultValidQ <= 1'b0;
      cntQ         <= '0;
      mcandQ       <= '0;
      mplierQ      <= '0;
      prodQ        <= '0;
    end else if (!bus.en) begin
      // Power-down aborts any multiply in flight without a result pulse.
      stateQ       <= ST_OFF;
      accQ         <= '0;
      ovfQ         <= 1'b0;
      resultValidQ <= 1'b0;
      cntQ         <= '0;
      mcandQ       <= '0;
      mplierQ      <= '0;
      prodQ        <= '0;
    end else begin
      resultValidQ <= 1'b0;
      case (stateQ)
        ST_OFF: begin
          stateQ <= ST_READY;
        end
        ST_READY: begin
          if (bus.load) begin
            accQ <= bus.load_val;
          end else if (accept) begin
            if (bus.opcode == OP_MUL) begin
              mcandQ  <= {{WIDTH{1'b0}}, accQ};
              mplierQ <= bus.operand;
              prodQ   <= '0;
              cntQ    <= CNT_INIT;
              stateQ  <= ST_RUN;
            end else begin
              accQ         <= aluOut[WIDTH-1:0];
              ovfQ         <= aluOut[WIDTH];
              resultValidQ <= 1'b1;
              stateQ       <= aluOut[WIDTH] ? ST_ERROR : ST_READY;
            end
          end
        end
        ST_RUN: begin
          // One partial product per cycle, multiplier LSB first.
          prodQ   <= stepProd;
          mcandQ  <= mcandQ << 1;
          mplierQ <= mplierQ >> 1;
          cntQ    <= cntQ - 1'b1;
          if (cntQ == CNT_LAST) begin
            accQ         <= stepProd[WIDTH-1:0];
            ovfQ         <= |stepProd[2*WIDTH-1:WIDTH];
            resultValidQ <= 1'b1;
            stateQ       <= (|stepProd[2*WIDTH-1:WIDTH]) ? ST_ERROR : ST_READY;
          end
        end
        default: begin
          if (bus.clr_err) begin
            ovfQ   <= 1'b0;
            stateQ <= ST_READY;
          end
        end
      endcase
    end
  end

  assign bus.op_ready     = opReady;
  assign bus.acc          = accQ;
  assign bus.result_valid = resultValidQ;
  assign bus.overflow     = ovfQ;
  assign bus.state        = stateQ;

endmodule
